key_search_ctrl: RTL and testbench

Brute-force key search controller for the ARC4 decryption core. It sequences an external `arc4` instance over a range of 24-bit keys. After each decryption it scans the length-prefixed plaintext memory and stops at the first key whose plaintext is entirely printable ASCII. It owns the single plaintext-memory port and shares it between `arc4` (write phase) and its own scanner (read phase).

---
 rtl/arc4_pkg.sv | 27 ++
 rtl/key_search_ctrl.sv | 166 ++++++++++++++++
 tb/tb_key_search_ctrl.sv | 344 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/arc4_pkg.sv
// Shared types and constants for the ARC4 key search controller.
// Covers the state encoding, the printable-ASCII window and the key width.
package arc4_pkg;

   localparam int KEY_W = 24;

   localparam logic [7:0] PRINT_LO = 8'h20;
   localparam logic [7:0] PRINT_HI = 8'h7E;

   typedef enum logic [3:0] {
      KS_IDLE      = 4'd0,
      KS_START     = 4'd1,
      KS_WAIT_BUSY = 4'd2,
      KS_WAIT_DONE = 4'd3,
      KS_RD_LEN    = 4'd4,
      KS_LEN_WAIT  = 4'd5,
      KS_RD_BYTE   = 4'd6,
      KS_BYTE_WAIT = 4'd7,
      KS_NEXT      = 4'd8,
      KS_DONE      = 4'd9
   } ks_state_t;

   function automatic logic is_print(input logic [7:0] b);
      return (b >= PRINT_LO) && (b <= PRINT_HI);
   endfunction

endpackage

// File: rtl/key_search_ctrl.sv
// Steps arc4 over a key range and scans each plaintext for printable ASCII.
// Owns the plaintext port: arc4 writes it, then the scanner reads it back.
module key_search_ctrl
   import arc4_pkg::*;
#(
   parameter logic [KEY_W-1:0] KEY_START = 24'h000000,
   parameter logic [KEY_W-1:0] KEY_STEP  = 24'h000001,
   parameter logic [KEY_W-1:0] KEY_LAST  = 24'hFFFFFF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   output logic             rdy,
   output logic [KEY_W-1:0] key,
   output logic             key_valid,
   output logic             a4_en,
   input  logic             a4_rdy,
   output logic [KEY_W-1:0] a4_key,
   input  logic [7:0]       a4_pt_addr,
   input  logic [7:0]       a4_pt_wrdata,
   input  logic             a4_pt_wren,
   output logic [7:0]       pt_addr,
   output logic [7:0]       pt_wrdata,
   output logic             pt_wren,
   input  logic [7:0]       pt_rddata
);

   ks_state_t        state_q, state_d;
   logic             rdy_q, rdy_d;
   logic [KEY_W-1:0] key_q, key_d;
   logic             key_valid_q, key_valid_d;
   logic             a4_en_q, a4_en_d;
   logic [KEY_W-1:0] a4_key_q, a4_key_d;
   logic [7:0]       addr_q, addr_d;
   logic [7:0]       len_q, len_d;
   logic [KEY_W:0]   next_key;
   logic             in_arc4;

   // Carry out of bit 23 means the step wrapped past the key space.
   assign next_key = {1'b0, a4_key_q} + {1'b0, KEY_STEP};

   always_comb begin
      state_d     = state_q;
      key_d       = key_q;
      key_valid_d = key_valid_q;
      a4_en_d     = 1'b0;
      a4_key_d    = a4_key_q;
      addr_d      = addr_q;
      len_d       = len_q;
      unique case (state_q)
         KS_IDLE, KS_DONE: begin
            if (en) begin
               state_d     = KS_START;
               key_valid_d = 1'b0;
               a4_key_d    = KEY_START;
            end
         end
         KS_START: begin
            if (a4_rdy) begin
               a4_en_d = 1'b1;
               state_d = KS_WAIT_BUSY;
            end
         end
         KS_WAIT_BUSY: begin
            if (!a4_rdy) state_d = KS_WAIT_DONE;
         end
         KS_WAIT_DONE: begin
            if (a4_rdy) begin
               addr_d  = 8'd0;
               state_d = KS_RD_LEN;
            end
         end
         KS_RD_LEN: begin
            state_d = KS_LEN_WAIT;
         end
         KS_LEN_WAIT: begin
            len_d = pt_rddata;
            if (pt_rddata == 8'd0) begin
               key_d       = a4_key_q;
               key_valid_d = 1'b1;
               state_d     = KS_DONE;
            end else begin
               addr_d  = 8'd1;
               state_d = KS_RD_BYTE;
            end
         end
         KS_RD_BYTE: begin
            state_d = KS_BYTE_WAIT;
         end
         KS_BYTE_WAIT: begin
            if (!is_print(pt_rddata)) begin
               state_d = KS_NEXT;
            end else if (addr_q == len_q) begin
               key_d       = a4_key_q;
               key_valid_d = 1'b1;
               state_d     = KS_DONE;
            end else begin
               addr_d  = addr_q + 8'd1;
               state_d = KS_RD_BYTE;
            end
         end
         KS_NEXT: begin
            if (next_key[KEY_W] ||
                (next_key[KEY_W-1:0] > KEY_LAST)) begin
               state_d = KS_DONE;
            end else begin
               a4_key_d = next_key[KEY_W-1:0];
               state_d  = KS_START;
            end
         end
         default: begin
            state_d = KS_IDLE;
         end
      endcase
      rdy_d = (state_d == KS_IDLE) || (state_d == KS_DONE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= KS_IDLE;
         rdy_q       <= 1'b1;
         key_q       <= '0;
         key_valid_q <= 1'b0;
         a4_en_q     <= 1'b0;
         a4_key_q    <= KEY_START;
         addr_q      <= 8'd0;
         len_q       <= 8'd0;
      end else begin
         state_q     <= state_d;
         rdy_q       <= rdy_d;
         key_q       <= key_d;
         key_valid_q <= key_valid_d;
         a4_en_q     <= a4_en_d;
         a4_key_q    <= a4_key_d;
         addr_q      <= addr_d;
         len_q       <= len_d;
      end
   end

   assign in_arc4 = (state_q == KS_START) ||
                    (state_q == KS_WAIT_BUSY) ||
                    (state_q == KS_WAIT_DONE);

   always_comb begin
      pt_addr   = addr_q;
      pt_wrdata = 8'd0;
      pt_wren   = 1'b0;
      unique case (1'b1)
         in_arc4: begin
            pt_addr   = a4_pt_addr;
            pt_wrdata = a4_pt_wrdata;
            pt_wren   = a4_pt_wren;
         end
         default: begin
            pt_addr   = addr_q;
         end
      endcase
   end

   assign rdy       = rdy_q;
   assign key       = key_q;
   assign key_valid = key_valid_q;
   assign a4_en     = a4_en_q;
   assign a4_key    = a4_key_q;

endmodule

// File: tb/tb_key_search_ctrl.sv
// Directed bench: three controllers with different key ranges, each
// driven by a behavioural arc4 stub and a plaintext memory model.
module tb_key_search_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        force_w = 1'b0;
   logic        en [3];
   logic        rdy [3];
   logic [23:0] key [3];
   logic        kv [3];
   logic        a4_en [3];
   logic        a4_rdy [3];
   logic [23:0] a4_key [3];
   logic [7:0]  pt_addr [3];
   logic [7:0]  pt_wrdata [3];
   logic        pt_wren [3];
   logic [7:0]  pt_rddata [3];

   logic        s_busy [3];
   logic [8:0]  s_cnt [3];
   logic [23:0] s_key [3];
   logic [7:0]  s_addr [3];
   logic [7:0]  s_data [3];
   logic        s_wren [3];
   logic [7:0]  en_cnt [3];
   logic [23:0] klog [3][16];
   logic [7:0]  mem [3][256];

   int          mode [3];
   logic [23:0] match [3];
   int          n_cmp = 0;
   int          n_bad = 0;

   always #5 clk = ~clk;

   key_search_ctrl u0 (
      .clk(clk), .rst_n(rst_n), .en(en[0]), .rdy(rdy[0]),
      .key(key[0]), .key_valid(kv[0]), .a4_en(a4_en[0]),
      .a4_rdy(a4_rdy[0]), .a4_key(a4_key[0]),
      .a4_pt_addr(force_w ? 8'h55 : s_addr[0]),
      .a4_pt_wrdata(force_w ? 8'hAA : s_data[0]),
      .a4_pt_wren(s_wren[0] | force_w),
      .pt_addr(pt_addr[0]), .pt_wrdata(pt_wrdata[0]),
      .pt_wren(pt_wren[0]), .pt_rddata(pt_rddata[0]));

   key_search_ctrl #(.KEY_START(24'd1), .KEY_STEP(24'd2)) u1 (
      .clk(clk), .rst_n(rst_n), .en(en[1]), .rdy(rdy[1]),
      .key(key[1]), .key_valid(kv[1]), .a4_en(a4_en[1]),
      .a4_rdy(a4_rdy[1]), .a4_key(a4_key[1]),
      .a4_pt_addr(force_w ? 8'h55 : s_addr[1]),
      .a4_pt_wrdata(force_w ? 8'hAA : s_data[1]),
      .a4_pt_wren(s_wren[1] | force_w),
      .pt_addr(pt_addr[1]), .pt_wrdata(pt_wrdata[1]),
      .pt_wren(pt_wren[1]), .pt_rddata(pt_rddata[1]));

   key_search_ctrl #(.KEY_LAST(24'd3)) u2 (
      .clk(clk), .rst_n(rst_n), .en(en[2]), .rdy(rdy[2]),
      .key(key[2]), .key_valid(kv[2]), .a4_en(a4_en[2]),
      .a4_rdy(a4_rdy[2]), .a4_key(a4_key[2]),
      .a4_pt_addr(force_w ? 8'h55 : s_addr[2]),
      .a4_pt_wrdata(force_w ? 8'hAA : s_data[2]),
      .a4_pt_wren(s_wren[2] | force_w),
      .pt_addr(pt_addr[2]), .pt_wrdata(pt_wrdata[2]),
      .pt_wren(pt_wren[2]), .pt_rddata(pt_rddata[2]));

   // Plaintext image per mode: index 0 is the length byte.
   function automatic logic [7:0] pt_byte(input int i,
                                          input logic [23:0] k,
                                          input logic [8:0] idx);
      logic hit;
      hit = (k == match[i]);
      pt_byte = 8'h00;
      if (mode[i] == 0) begin
         case (idx)
            9'd0: pt_byte = 8'd3;
            9'd1: pt_byte = 8'h61;
            9'd2: pt_byte = hit ? 8'h62 : 8'h01;
            9'd3: pt_byte = 8'h63;
            default: pt_byte = 8'h00;
         endcase
      end else if (mode[i] == 1) begin
         if (k == 24'd0) begin
            case (idx)
               9'd0: pt_byte = 8'd3;
               9'd1: pt_byte = 8'h20;
               9'd2: pt_byte = 8'h7E;
               9'd3: pt_byte = 8'h7F;
               default: pt_byte = 8'h00;
            endcase
         end else if (k == 24'd1) begin
            case (idx)
               9'd0: pt_byte = 8'd3;
               9'd1: pt_byte = 8'h1F;
               9'd2: pt_byte = 8'h41;
               9'd3: pt_byte = 8'h41;
               default: pt_byte = 8'h00;
            endcase
         end else begin
            case (idx)
               9'd0: pt_byte = 8'd2;
               9'd1: pt_byte = 8'h20;
               9'd2: pt_byte = 8'h7E;
               default: pt_byte = 8'h00;
            endcase
         end
      end
   endfunction

   initial begin
      for (int i = 0; i < 3; i++) en_cnt[i] = 8'd0;
   end

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 3; i++) begin
            s_busy[i] <= 1'b0;
            s_cnt[i]  <= 9'd0;
            s_key[i]  <= 24'd0;
            s_addr[i] <= 8'd0;
            s_data[i] <= 8'd0;
            s_wren[i] <= 1'b0;
            a4_rdy[i] <= 1'b1;
         end
      end else begin
         for (int i = 0; i < 3; i++) begin
            if (!s_busy[i]) begin
               s_wren[i] <= 1'b0;
               if (a4_en[i]) begin
                  klog[i][en_cnt[i][3:0]] <= a4_key[i];
                  en_cnt[i] <= en_cnt[i] + 8'd1;
                  s_busy[i] <= 1'b1;
                  a4_rdy[i] <= 1'b0;
                  s_key[i]  <= a4_key[i];
                  s_cnt[i]  <= 9'd1;
                  s_addr[i] <= 8'd0;
                  s_data[i] <= pt_byte(i, a4_key[i], 9'd0);
                  s_wren[i] <= 1'b1;
               end
            end else if (s_cnt[i] <= {1'b0, pt_byte(i, s_key[i], 9'd0)}) begin
               s_addr[i] <= s_cnt[i][7:0];
               s_data[i] <= pt_byte(i, s_key[i], s_cnt[i]);
               s_wren[i] <= 1'b1;
               s_cnt[i]  <= s_cnt[i] + 9'd1;
            end else begin
               s_wren[i] <= 1'b0;
               s_busy[i] <= 1'b0;
               a4_rdy[i] <= 1'b1;
            end
         end
      end
   end

   always @(posedge clk) begin
      for (int i = 0; i < 3; i++) begin
         if (pt_wren[i]) mem[i][pt_addr[i]] <= pt_wrdata[i];
         pt_rddata[i] <= mem[i][pt_addr[i]];
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic pulse(input int i);
      @(negedge clk);
      en[i] = 1'b1;
      @(negedge clk);
      en[i] = 1'b0;
   endtask

   task automatic wait_rdy(input int i, input string tag);
      int k;
      k = 0;
      while (!rdy[i] && k < 3000) begin
         @(negedge clk);
         k++;
      end
      if (!rdy[i]) chk({tag, "_timeout"}, 32'd0, 32'd1);
   endtask

   function automatic logic [23:0] log_at(input int i, input logic [7:0] b,
                                          input int j);
      logic [3:0] idx;
      idx = 4'(b + 8'(j));
      return klog[i][idx];
   endfunction

   logic [7:0] base;
   int         k;

   initial begin
      for (int i = 0; i < 3; i++) begin
         en[i] = 1'b0;
         mode[i] = 0;
         match[i] = 24'hFFFFFF;
      end
      match[0] = 24'd2;
      match[1] = 24'd5;
      repeat (3) @(negedge clk);
      chk("rst_rdy", 32'(rdy[0]), 32'd1);
      chk("rst_kv", 32'(kv[0]), 32'd0);
      chk("rst_key", 32'(key[0]), 32'd0);
      chk("rst_a4en", 32'(a4_en[0]), 32'd0);
      chk("rst_wren", 32'(pt_wren[0]), 32'd0);
      chk("rst_a4key0", 32'(a4_key[0]), 32'd0);
      chk("rst_a4key1", 32'(a4_key[1]), 32'd1);
      chk("rst_addr", 32'(pt_addr[0]), 32'd0);
      chk("rst_wrdata", 32'(pt_wrdata[0]), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // Match at key 2 with the default range.
      base = en_cnt[0];
      pulse(0);
      chk("busy_rdy", 32'(rdy[0]), 32'd0);
      wait_rdy(0, "abc");
      chk("abc_key", 32'(key[0]), 32'd2);
      chk("abc_kv", 32'(kv[0]), 32'd1);
      chk("abc_runs", 32'(en_cnt[0] - base), 32'd3);
      chk("abc_k0", 32'(log_at(0, base, 0)), 32'd0);
      chk("abc_k1", 32'(log_at(0, base, 1)), 32'd1);
      chk("abc_k2", 32'(log_at(0, base, 2)), 32'd2);
      chk("abc_mem0", 32'(mem[0][0]), 32'h03);
      chk("abc_mem2", 32'(mem[0][2]), 32'h62);
      chk("abc_mem3", 32'(mem[0][3]), 32'h63);

      // arc4 write strobes must not leak through outside the arc4 phase.
      @(negedge clk);
      force_w = 1'b1;
      #1;
      chk("leak_wren", 32'(pt_wren[0]), 32'd0);
      chk("leak_wrdata", 32'(pt_wrdata[0]), 32'd0);
      @(negedge clk);
      force_w = 1'b0;

      // Odd keys only, match at 5.
      base = en_cnt[1];
      pulse(1);
      k = 0;
      while (!s_wren[1] && k < 100) begin
         @(negedge clk);
         k++;
      end
      chk("pass_wren", 32'(pt_wren[1]), 32'd1);
      chk("pass_addr", 32'(pt_addr[1]), 32'(s_addr[1]));
      chk("pass_data", 32'(pt_wrdata[1]), 32'(s_data[1]));
      wait_rdy(1, "odd");
      chk("odd_key", 32'(key[1]), 32'd5);
      chk("odd_kv", 32'(kv[1]), 32'd1);
      chk("odd_runs", 32'(en_cnt[1] - base), 32'd3);
      chk("odd_k0", 32'(log_at(1, base, 0)), 32'd1);
      chk("odd_k1", 32'(log_at(1, base, 1)), 32'd3);
      chk("odd_k2", 32'(log_at(1, base, 2)), 32'd5);

      // Empty plaintext succeeds on the first key.
      mode[0] = 2;
      base = en_cnt[0];
      pulse(0);
      chk("en_clr_kv", 32'(kv[0]), 32'd0);
      wait_rdy(0, "len0");
      chk("len0_key", 32'(key[0]), 32'd0);
      chk("len0_kv", 32'(kv[0]), 32'd1);
      chk("len0_runs", 32'(en_cnt[0] - base), 32'd1);

      // Printable window edges: 7F and 1F reject, 20 and 7E accept.
      mode[0] = 1;
      base = en_cnt[0];
      pulse(0);
      wait_rdy(0, "edge");
      chk("edge_key", 32'(key[0]), 32'd2);
      chk("edge_kv", 32'(kv[0]), 32'd1);
      chk("edge_runs", 32'(en_cnt[0] - base), 32'd3);

      // Exhaust keys 0..3; an en during WAIT_DONE is ignored.
      base = en_cnt[2];
      pulse(2);
      k = 0;
      while (a4_rdy[2] && k < 100) begin
         @(negedge clk);
         k++;
      end
      @(negedge clk);
      en[2] = 1'b1;
      @(negedge clk);
      en[2] = 1'b0;
      wait_rdy(2, "exh");
      chk("exh_kv", 32'(kv[2]), 32'd0);
      chk("exh_runs", 32'(en_cnt[2] - base), 32'd4);
      chk("exh_k3", 32'(log_at(2, base, 3)), 32'd3);
      repeat (60) @(negedge clk);
      chk("exh_idle_runs", 32'(en_cnt[2] - base), 32'd4);
      chk("exh_rdy", 32'(rdy[2]), 32'd1);

      // Reset during WAIT_DONE of key 1, then a fresh search.
      mode[0] = 0;
      base = en_cnt[0];
      pulse(0);
      k = 0;
      while (en_cnt[0] != base + 8'd2 && k < 500) begin
         @(negedge clk);
         k++;
      end
      @(negedge clk);
      chk("pre_a4key", 32'(a4_key[0]), 32'd1);
      chk("pre_rdy", 32'(rdy[0]), 32'd0);
      rst_n = 1'b0;
      #1;
      chk("mid_rdy", 32'(rdy[0]), 32'd1);
      chk("mid_kv", 32'(kv[0]), 32'd0);
      chk("mid_key", 32'(key[0]), 32'd0);
      chk("mid_a4en", 32'(a4_en[0]), 32'd0);
      chk("mid_a4key", 32'(a4_key[0]), 32'd0);
      chk("mid_wren", 32'(pt_wren[0]), 32'd0);
      chk("mid_addr", 32'(pt_addr[0]), 32'd0);
      chk("mid_wrdata", 32'(pt_wrdata[0]), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      base = en_cnt[0];
      pulse(0);
      wait_rdy(0, "again");
      chk("again_k0", 32'(log_at(0, base, 0)), 32'd0);
      chk("again_key", 32'(key[0]), 32'd2);
      chk("again_kv", 32'(kv[0]), 32'd1);
      chk("again_runs", 32'(en_cnt[0] - base), 32'd3);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: observed running expected finished");
      $fatal(1, "watchdog");
   end

endmodule
